sd_sec_read_arbiter: RTL

Two-port arbiter that shares the single sector-read channel of the SD card SPI controller between two requesters (port 0: BMP image reader; port 1: secondary loader, e.g. font/config sectors). Grants are round-robin and held for one whole 512-byte sector, from request to `sd_sec_read_end`. Read data and end pulses are routed back to the owning port only. The block sits between the requesters and the SD controller's `sd_sec_read*` interface and blocks all grants until card initialization completes.

---
 rtl/sd_sec_read_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sd_sec_read_arbiter.sv
// sd_sec_read_arbiter
// Shares the SD controller's single sector-read channel between two requesters
// (port 0: BMP image reader, port 1: secondary loader). Ownership is granted
// round-robin and held for one whole sector, from grant until the controller's
// sector-done pulse. Read strobes and done pulses go back to the owning port only.
// No grant is issued until sd_init_done is high.
//
// Optional build macro: SD_ARB_TIMEOUT_EN adds a watchdog that ends a sector early
// after TIMEOUT_CYCLES cycles without a data byte, and sets the sticky timeout_err flag.
module sd_sec_read_arbiter #(
    parameter int          GAP_CYCLES     = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_init_done,
    input  logic        req0_read,
    input  logic        req1_read,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req1_addr,
    output logic        req0_grant,
    output logic        req1_grant,
    output logic        req0_data_valid,
    output logic        req1_data_valid,
    output logic        req0_end,
    output logic        req1_end,
    output logic [7:0]  rd_data,
    output logic        sd_sec_read,
    output logic [31:0] sd_sec_read_addr,
    input  logic [7:0]  sd_sec_read_data,
    input  logic        sd_sec_read_data_valid,
    input  logic        sd_sec_read_end,
    output logic        busy,
    output logic        timeout_err
);

    // Gap counter runs 0 .. GAP_CYCLES-1, so it needs at least one bit.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              last_reg, last_next;
    logic [31:0]       addr_reg, addr_next;
    logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
    logic              sel;
    logic              in_busy;
    logic              timeout_hit;
    logic              sector_done;
    logic [1:0]        grant_vec;
    logic [1:0]        valid_vec;
    logic [1:0]        end_vec;

    assign in_busy     = (state_reg == BUSY);
    assign sector_done = sd_sec_read_end || timeout_hit;

    // State, ownership and latched address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            owner_reg   <= 1'b0;
            last_reg    <= 1'b1;
            addr_reg    <= 32'd0;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            last_reg    <= last_next;
            addr_reg    <= addr_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    // Next-state logic: round-robin pick in IDLE, hold for one sector, then a forced gap.
    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        last_next    = last_reg;
        addr_next    = addr_reg;
        gap_cnt_next = gap_cnt_reg;
        // When both ports ask, the one that did not win last time goes next.
        sel          = (req0_read && req1_read) ? ~last_reg : req1_read;
        case (state_reg)
            IDLE: begin
                if (sd_init_done && (req0_read || req1_read)) begin
                    owner_next = sel;
                    last_next  = sel;
                    addr_next  = sel ? req1_addr : req0_addr;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (sector_done) begin
                    gap_cnt_next = '0;
                    state_next   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-port routing: grant, byte strobe and done pulse reach the owner only.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign grant_vec[gi] = in_busy && ((gi == 1) ? owner_reg : ~owner_reg);
            assign valid_vec[gi] = grant_vec[gi] && sd_sec_read_data_valid;
            assign end_vec[gi]   = grant_vec[gi] && sector_done;
        end
    endgenerate

    assign req0_grant       = grant_vec[0];
    assign req1_grant       = grant_vec[1];
    assign req0_data_valid  = valid_vec[0];
    assign req1_data_valid  = valid_vec[1];
    assign req0_end         = end_vec[0];
    assign req1_end         = end_vec[1];
    assign rd_data          = sd_sec_read_data;
    assign sd_sec_read      = in_busy;
    assign sd_sec_read_addr = addr_reg;
    assign busy             = (state_reg != IDLE);

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] wd_cnt_reg;
    logic        timeout_err_reg;

    // Watchdog: counts idle cycles while owning the channel, restarted by every byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_reg      <= 24'd0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (!in_busy || sd_sec_read_data_valid) begin
                wd_cnt_reg <= 24'd0;
            end else begin
                wd_cnt_reg <= wd_cnt_reg + 24'd1;
            end
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_hit = in_busy && (wd_cnt_reg >= TIMEOUT_CYCLES);
    assign timeout_err = timeout_err_reg;
`else
    // Watchdog compiled out: a stalled sector keeps the channel until its end pulse.
    // The parameter is still referenced so both builds share one interface.
    assign timeout_hit = 1'b0;
    assign timeout_err = (TIMEOUT_CYCLES == 24'd0) && 1'b0;
`endif

endmodule
